// File: rtl/ahb_rr_arbiter.sv
// Round-robin arbiter sharing one AHB slave port (the APB bridge) between NUM_MASTERS masters.
// Define ARB_LOCK_EN to let hlock[owner] pin the current owner; otherwise hlock is ignored.
//
// state | meaning
// PARK  | no request pending, master 0 granted by default, htrans forced IDLE
// OWN   | a requesting master holds the address phase
module ahb_rr_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MAX_HOLD    = 16
) (
   input  logic                          hclk,
   input  logic                          hreset,
   input  logic [NUM_MASTERS-1:0]        hbusreq,
   input  logic [NUM_MASTERS-1:0]        hlock,
   input  logic [NUM_MASTERS*ADDR_W-1:0] m_haddr,
   input  logic [NUM_MASTERS*2-1:0]      m_htrans,
   input  logic [NUM_MASTERS-1:0]        m_hwrite,
   input  logic [NUM_MASTERS*DATA_W-1:0] m_hwdata,
   output logic [NUM_MASTERS-1:0]        hgrant,
   output logic [$clog2(NUM_MASTERS)-1:0] hmaster,
   output logic [ADDR_W-1:0]             haddr,
   output logic [1:0]                    htrans,
   output logic                          hwrite,
   output logic [DATA_W-1:0]             hwdata,
   input  logic                          hready
);
   localparam int IDX_W  = $clog2(NUM_MASTERS);
   localparam int HOLD_W = $clog2(MAX_HOLD);
   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;

   typedef enum logic {ST_PARK = 1'b0, ST_OWN = 1'b1} state_t;

   state_t                  r_state, w_state_nxt;
   logic [IDX_W-1:0]        r_owner, w_owner_nxt;
   logic [IDX_W-1:0]        r_data_owner;
   logic [IDX_W-1:0]        r_rr_ptr, w_rr_nxt;
   logic [HOLD_W-1:0]       r_hold_cnt, w_hold_nxt;
   logic [NUM_MASTERS-1:0]  r_hgrant, w_grant_nxt;
   logic [IDX_W-1:0]        r_hmaster;
   logic [NUM_MASTERS-1:0]  w_req_others;
   logic [IDX_W-1:0]        w_win;
   logic [1:0]              w_owner_trans;
   logic                    w_locked;
   logic                    w_hold_hit;
   logic                    w_rearb;

   // First requester strictly after ptr, wrapping modulo NUM_MASTERS.
   function automatic logic [IDX_W-1:0] f_winner(input logic [NUM_MASTERS-1:0] req,
                                                  input logic [IDX_W-1:0] ptr);
      logic [IDX_W-1:0] win;
      logic             found;
      int               idx;
      win   = '0;
      found = 1'b0;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = IDX_W'(idx);
         end
      end
      return win;
   endfunction

`ifdef ARB_LOCK_EN
   assign w_locked = (r_state == ST_OWN) && hlock[r_owner];
`else
   logic w_unused_hlock;
   assign w_unused_hlock = ^hlock;
   assign w_locked       = 1'b0;
`endif

   always_comb begin
      w_owner_trans = m_htrans[int'(r_owner)*2 +: 2];
      // The owner never competes against itself when its hold limit expires.
      w_req_others = hbusreq;
      if (r_state == ST_OWN) w_req_others[r_owner] = 1'b0;
      w_win      = f_winner(w_req_others, r_rr_ptr);
      w_hold_hit = (r_hold_cnt >= HOLD_W'(MAX_HOLD-1)) && (|w_req_others) &&
                   ((w_owner_trans == TR_IDLE) || (w_owner_trans == TR_NONSEQ));
      w_rearb    = !w_locked && (!hbusreq[r_owner] || w_hold_hit);
   end

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_hold_nxt  = r_hold_cnt;
      w_rr_nxt    = r_rr_ptr;
      if (hready) begin
         case (r_state)
            ST_PARK: begin
               if (|hbusreq) begin
                  w_state_nxt = ST_OWN;
                  w_owner_nxt = w_win;
                  w_hold_nxt  = '0;
                  w_rr_nxt    = w_win;
               end
            end
            ST_OWN: begin
               if (w_rearb) begin
                  w_hold_nxt = '0;
                  if (|w_req_others) begin
                     w_owner_nxt = w_win;
                     w_rr_nxt    = w_win;
                  end else begin
                     w_state_nxt = ST_PARK;
                     w_owner_nxt = '0;
                  end
               end else if (!w_locked &&
                            ((w_owner_trans == TR_NONSEQ) || (w_owner_trans == TR_SEQ)) &&
                            (r_hold_cnt < HOLD_W'(MAX_HOLD-1))) begin
                  w_hold_nxt = r_hold_cnt + HOLD_W'(1);
               end
            end
            default: begin
               w_state_nxt = ST_PARK;
               w_owner_nxt = '0;
               w_hold_nxt  = '0;
            end
         endcase
      end
      w_grant_nxt              = '0;
      w_grant_nxt[w_owner_nxt] = 1'b1;
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         r_state      <= ST_PARK;
         r_owner      <= '0;
         r_data_owner <= '0;
         r_hold_cnt   <= '0;
         r_rr_ptr     <= IDX_W'(NUM_MASTERS-1);
         r_hgrant     <= NUM_MASTERS'(1);
         r_hmaster    <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_owner    <= w_owner_nxt;
         r_hold_cnt <= w_hold_nxt;
         r_rr_ptr   <= w_rr_nxt;
         r_hgrant   <= w_grant_nxt;
         r_hmaster  <= w_owner_nxt;
         if (hready) r_data_owner <= r_owner;
      end
   end

   assign hgrant  = r_hgrant;
   assign hmaster = r_hmaster;
   assign haddr   = m_haddr[int'(r_owner)*ADDR_W +: ADDR_W];
   assign htrans  = (r_state == ST_PARK) ? TR_IDLE : w_owner_trans;
   assign hwrite  = m_hwrite[r_owner];
   assign hwdata  = m_hwdata[int'(r_data_owner)*DATA_W +: DATA_W];

endmodule
